// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and broadcast fabric for a shared snooping bus between NUM_CORES cores.
// Latency: grant 1 cycle after the request; the owner's op/addr/data reach bus_*_out 1 cycle after sampling; snoop hits are combinational.
// Backpressure: none; an owner keeps the bus while it requests, for at most MAX_HOLD cycles, and then one GAP cycle follows.
// Ports: clk/reset (sync, active-high); req_core, core_operation_in, core_address_in, core_data_in, core_hit_in (per core);
//        grant, bus_operation_out, bus_address_out, bus_data_out, cache_hit_out, bus_owner, bus_busy.
module snoop_bus_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_HOLD  = 64,
  localparam int OWNER_W  = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1,
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_core,
  input  logic [2*NUM_CORES-1:0]        core_operation_in,
  input  logic [ADDR_W*NUM_CORES-1:0]   core_address_in,
  input  logic [DATA_W*NUM_CORES-1:0]   core_data_in,
  input  logic [NUM_CORES-1:0]          core_hit_in,
  output logic [NUM_CORES-1:0]          grant,
  output logic [1:0]                    bus_operation_out,
  output logic [ADDR_W-1:0]             bus_address_out,
  output logic [DATA_W-1:0]             bus_data_out,
  output logic [2*NUM_CORES-1:0]        cache_hit_out,
  output logic [OWNER_W-1:0]            bus_owner,
  output logic                          bus_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [1:0] OP_NONE = 2'b11;

  logic [1:0]           state;
  logic [OWNER_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]    hold_cnt;

  // Arbitration: first requester found scanning from rr_ptr upward with wrap.
  logic                 any_req;
  logic [OWNER_W-1:0]   sel;

  always_comb begin
    int idx;
    any_req = 1'b0;
    sel     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (!any_req && req_core[idx]) begin
        any_req = 1'b1;
        sel     = OWNER_W'(idx);
      end
    end
  end

  // Current owner's request and bus transaction.
  logic                 owner_req;
  logic [1:0]           owner_op;
  logic [ADDR_W-1:0]    owner_addr;
  logic [DATA_W-1:0]    owner_data;

  always_comb begin
    int oi;
    oi         = int'(bus_owner);
    owner_req  = req_core[oi];
    owner_op   = core_operation_in[2*oi +: 2];
    owner_addr = core_address_in[ADDR_W*oi +: ADDR_W];
    owner_data = core_data_in[DATA_W*oi +: DATA_W];
  end

  logic [OWNER_W-1:0] next_rr;
  assign next_rr = (bus_owner == OWNER_W'(NUM_CORES - 1)) ? '0 : bus_owner + 1'b1;

  logic release_bus;
  assign release_bus = !owner_req || (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      grant             <= '0;
      bus_operation_out <= OP_NONE;
      bus_address_out   <= '0;
      bus_data_out      <= '0;
      bus_owner         <= '0;
      bus_busy          <= 1'b0;
      rr_ptr            <= '0;
      hold_cnt          <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          bus_operation_out <= OP_NONE;
          if (any_req) begin
            grant     <= {{(NUM_CORES-1){1'b0}}, 1'b1} << sel;
            bus_owner <= sel;
            bus_busy  <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
            state     <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (release_bus) begin
            // Address/data keep their last broadcast values through GAP.
            grant             <= '0;
            bus_busy          <= 1'b0;
            bus_operation_out <= OP_NONE;
            rr_ptr            <= next_rr;
            state             <= GAP;
          end else begin
            bus_operation_out <= owner_op;
            bus_address_out   <= owner_addr;
            bus_data_out      <= owner_data;
            if (hold_cnt != HOLD_W'(MAX_HOLD))
              hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Snoop result goes only to the owner: any other core hit, and two-or-more others hit.
  always_comb begin
    int cnt;
    int oi;
    cache_hit_out = '0;
    cnt           = 0;
    oi            = int'(bus_owner);
    for (int j = 0; j < NUM_CORES; j++) begin
      if (j != oi && core_hit_in[j])
        cnt = cnt + 1;
    end
    if (bus_busy) begin
      cache_hit_out[2*oi]     = (cnt >= 1);
      cache_hit_out[2*oi + 1] = (cnt >= 2);
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: NUM_CORES=4, MAX_HOLD=4, 32-bit address/data.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Each scenario task carries its own expected values.
module tb_snoop_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_core;
  logic [2*N-1:0]  core_operation_in;
  logic [AW*N-1:0] core_address_in;
  logic [DW*N-1:0] core_data_in;
  logic [N-1:0]    core_hit_in;
  logic [N-1:0]    grant;
  logic [1:0]      bus_operation_out;
  logic [AW-1:0]   bus_address_out;
  logic [DW-1:0]   bus_data_out;
  logic [2*N-1:0]  cache_hit_out;
  logic [1:0]      bus_owner;
  logic            bus_busy;

  int checks = 0;
  int errors = 0;

  snoop_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req_core(req_core),
    .core_operation_in(core_operation_in), .core_address_in(core_address_in),
    .core_data_in(core_data_in), .core_hit_in(core_hit_in),
    .grant(grant), .bus_operation_out(bus_operation_out),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .cache_hit_out(cache_hit_out), .bus_owner(bus_owner), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_core = '0;
    core_hit_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_core = 4'b1111;
    core_operation_in = '0;
    core_address_in = '0;
    core_data_in = '0;
    core_hit_in = '0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b exp 0000", grant); end
    checks++; if (bus_operation_out !== 2'b11) begin errors++; $display("FAIL rst_op: got %b exp 11", bus_operation_out); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus_busy); end
    checks++; if (bus_address_out !== 32'h0 || bus_data_out !== 32'h0) begin errors++; $display("FAIL rst_addr_data: got %h/%h exp 0/0", bus_address_out, bus_data_out); end
    checks++; if (cache_hit_out !== 8'h00) begin errors++; $display("FAIL rst_hit: got %b exp 0", cache_hit_out); end
    reset = 1'b0;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b exp 0001", grant); end
    checks++; if (bus_owner !== 2'd0 || bus_busy !== 1'b1) begin errors++; $display("FAIL rst_first_owner: got owner %0d busy %b exp 0/1", bus_owner, bus_busy); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
    do_reset();
    req_core = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      checks++; if (grant !== order[g]) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", g, grant, order[g]); end
      if (g == 4) break;
      tick();
      tick();
      checks++; if (grant !== order[g]) begin errors++; $display("FAIL rr_hold%0d: got %b exp %b", g, grant, order[g]); end
      req_core = req_core & ~order[g];
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b exp 0000", g, grant); end
      req_core = 4'b1111;
      tick();
    end
    req_core = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req_core = 4'b0100;
    tick();
    req_core = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_hold%0d: got %b exp 0100", c, grant); end
      if (c < 4) tick();
    end
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_gap: got %b exp 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_next: got %b exp 0001", grant); end
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_next_hold: got %b exp 0001", grant); end
    req_core = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_gap2: got %b exp 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_regrant: got %b exp 0100", grant); end
    req_core = '0;
    tick();
    tick();
  endtask

  task automatic test_broadcast();
    do_reset();
    core_operation_in = 8'b01_01_10_01;
    core_address_in = {32'h3333_3333, 32'h2222_2222, 32'h0000_0040, 32'h1111_1111};
    core_data_in = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hDEAD_BEEF, 32'hAAAA_AAAA};
    req_core = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010 || bus_owner !== 2'd1) begin errors++; $display("FAIL bc_grant: got %b owner %0d exp 0010 owner 1", grant, bus_owner); end
    checks++; if (bus_operation_out !== 2'b11) begin errors++; $display("FAIL bc_op_early: got %b exp 11", bus_operation_out); end
    tick();
    checks++; if (bus_operation_out !== 2'b10) begin errors++; $display("FAIL bc_op: got %b exp 10", bus_operation_out); end
    checks++; if (bus_address_out !== 32'h0000_0040) begin errors++; $display("FAIL bc_addr: got %h exp 00000040", bus_address_out); end
    checks++; if (bus_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bc_data: got %h exp deadbeef", bus_data_out); end
    core_operation_in = 8'b00_00_10_00;
    core_address_in[31:0] = 32'h5555_5555;
    tick();
    checks++; if (bus_operation_out !== 2'b10 || bus_address_out !== 32'h0000_0040) begin errors++; $display("FAIL bc_ignore: got %b/%h exp 10/00000040", bus_operation_out, bus_address_out); end
    req_core = '0;
    tick();
    checks++; if (bus_operation_out !== 2'b11 || bus_address_out !== 32'h0000_0040) begin errors++; $display("FAIL bc_gap: got %b/%h exp 11/00000040", bus_operation_out, bus_address_out); end
    tick();
  endtask

  task automatic test_snoop();
    do_reset();
    core_hit_in = 4'b1111;
    #1;
    checks++; if (cache_hit_out !== 8'h00) begin errors++; $display("FAIL sn_idle: got %b exp 00000000", cache_hit_out); end
    req_core = 4'b0001;
    tick();
    core_hit_in = 4'b0110;
    #1;
    checks++; if (cache_hit_out !== 8'b0000_0011) begin errors++; $display("FAIL sn_two: got %b exp 00000011", cache_hit_out); end
    core_hit_in = 4'b0011;
    #1;
    checks++; if (cache_hit_out !== 8'b0000_0001) begin errors++; $display("FAIL sn_one: got %b exp 00000001", cache_hit_out); end
    core_hit_in = 4'b0001;
    #1;
    checks++; if (cache_hit_out !== 8'b0000_0000) begin errors++; $display("FAIL sn_self: got %b exp 00000000", cache_hit_out); end
    core_hit_in = '0;
    req_core = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_core = 4'b0100;
    tick();
    req_core = 4'b0000;
    tick();
    req_core = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rm_setup: got %b exp 0010", grant); end
    tick();
    tick();
    reset = 1'b1;
    req_core = 4'b1010;
    tick();
    checks++; if (grant !== 4'b0000 || bus_busy !== 1'b0) begin errors++; $display("FAIL rm_grant: got %b busy %b exp 0000/0", grant, bus_busy); end
    checks++; if (bus_operation_out !== 2'b11 || bus_owner !== 2'd0) begin errors++; $display("FAIL rm_op_owner: got %b/%0d exp 11/0", bus_operation_out, bus_owner); end
    reset = 1'b0;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rm_restart: got %b exp 0010", grant); end
    req_core = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_broadcast();
    test_snoop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
